shiftin: RTL and testbench
==========================

Name: shiftin

Overview:
- Serial-to-parallel deserializer; receive end of the LSB-first serial link driven by the team's serializer.
- Samples one bit per enabled clock, assembles a DATA_WIDTH word, presents it on a held output register and flags completion on Fx.
- Output register is double-buffered against the assembly register, so the next word can stream in while the previous one awaits Ack.
- Sits at the multiplier's operand input side, feeding parallel operands from the serial link.

Parameters:
- DATA_WIDTH, 16, bits per word.
- COUNTER_WIDTH, 5, bit-index counter width; must satisfy 2**COUNTER_WIDTH > DATA_WIDTH.

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- Sx  input  1  shift enable; when high, Z_in is a valid bit this cycle.
- Z_in  input  1  serial data, LSB first.
- Ack  input  1  consumer has taken Z_parallel; clears Fx and Ovf.
- Z_parallel  output  DATA_WIDTH  last completed word, held until the next completed word is loaded.
- Fx  output  1  word-ready flag, level, held until Ack.
- Ovf  output  1  sticky overrun flag.
- Busy  output  1  high while a word is partially assembled (counter != 0).

Behaviour:
- Reset (reset=0, async): Z_parallel=0, Fx=0, Ovf=0, Busy=0, counter=0, assembly register=0.
- Capture:
  - Each edge with Sx=1: assembly[counter] <= Z_in; counter <= counter+1.
  - Sx=0: counter and assembly register hold. A pause mid-word is legal and resumes at the same bit index.
  - No timeout.
- Completion:
  - The edge that captures bit DATA_WIDTH-1 also loads Z_parallel with the full word, including that bit. No extra latency.
  - On that same edge: counter <= 0 and Fx <= 1, both visible after the edge.
  - Word latency is DATA_WIDTH enabled cycles from the first bit.
- Output register states (FSM):
  - EMPTY (Fx=0): on completion -> FULL, load word.
  - FULL (Fx=1), Ack=1 without completion: -> EMPTY; Fx <= 0, Ovf <= 0.
  - FULL (Fx=1), completion with Ack=1 on the same edge: load new word, stay FULL (Fx=1), Ovf <= 0. This is not an overrun.
  - FULL (Fx=1), completion with Ack=0: overrun. New word is discarded, Z_parallel keeps the old word, Fx stays 1, Ovf <= 1. Ovf stays set until Ack.
  - Ack while EMPTY: ignored.
- Assembly continues regardless of the FSM state; Sx is never back-pressured.
- Busy: combinational (counter != 0); 0 between words.
- Counter never exceeds DATA_WIDTH-1; no wrap beyond the word boundary.
- Reset asserted mid-word: the partial word is lost and the counter returns to 0. After release, the first Sx bit is bit 0.
- Reset deassertion is synchronised externally; the block only requires an async assert.

Decomposition:
- Shared package: DATA_WIDTH and COUNTER_WIDTH defaults (shared with the serializer so both ends agree), and the EMPTY/FULL state encoding constants.
- No sub-module. Counter, assembly register and 2-state output FSM fit comfortably in one module of roughly 150 lines.

Test Plan:
- Reset, then 16 consecutive Sx=1 cycles carrying 16'hA5C3 LSB first -> after the 16th edge Z_parallel=16'hA5C3, Fx=1, Busy=0, Ovf=0. Ack for 1 cycle -> Fx=0, Z_parallel still 16'hA5C3.
- 16'h1234 sent with Sx=0 gaps of 3 cycles after bits 4 and 11 -> Busy=1 through the gaps, Z_parallel=16'h1234 and Fx=1 only after the 16th enabled bit.
- Back-to-back 16'hFFFF then 16'h0001, Ack pulsed on the 16th edge of the second word -> Z_parallel=16'h0001, Fx=1 continuous, Ovf=0.
- 16'hBEEF completes, no Ack, then 16'hDEAD completes -> Z_parallel=16'hBEEF, Fx=1, Ovf=1. Ack -> Fx=0, Ovf=0.
- reset low asynchronously (between edges) after 7 bits of 16'hCAFE -> all outputs 0 immediately. Release, send 16'h00FF -> Z_parallel=16'h00FF after exactly 16 enabled bits.
- Ack while Fx=0 -> no change to Fx, Ovf or Z_parallel.

Source files
------------

// File: rtl/shiftin_pkg.sv
// rtl/shiftin_pkg.sv - shared word geometry and output-register state encoding for the serial link
package shiftin_pkg;

  // Defaults shared with the serializer so both ends of the link agree on word size.
  localparam int SHIFTIN_DATA_WIDTH    = 16;
  localparam int SHIFTIN_COUNTER_WIDTH = 5;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/shiftin.sv
// rtl/shiftin.sv - LSB-first serial-to-parallel deserializer with double-buffered output word
module shiftin
  import shiftin_pkg::*;
#(
  parameter int DATA_WIDTH    = SHIFTIN_DATA_WIDTH,
  parameter int COUNTER_WIDTH = SHIFTIN_COUNTER_WIDTH
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  Sx,
  input  logic                  Z_in,
  input  logic                  Ack,
  output logic [DATA_WIDTH-1:0] Z_parallel,
  output logic                  Fx,
  output logic                  Ovf,
  output logic                  Busy
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic [COUNTER_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0]    assembly;
  logic [DATA_WIDTH-1:0]    word_next;
  logic [0:0]               state;
  logic                     complete;

  // word_next includes the bit arriving this cycle, so the completing edge loads the whole word.
  always_comb begin
    word_next = assembly;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (counter == COUNTER_WIDTH'(i)) begin
        word_next[i] = Z_in;
      end
    end
  end

  assign complete = Sx && (counter == LAST_IDX);
  assign Busy     = (counter != '0);
  assign Fx       = (state == ST_FULL);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      assembly <= '0;
    end else if (Sx) begin
      assembly <= word_next;
      counter  <= complete ? '0 : counter + 1'b1;
    end
  end

  // A completion while FULL only replaces the word if the consumer acks on the same edge.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      Z_parallel <= '0;
      Ovf        <= 1'b0;
    end else if (complete) begin
      if ((state == ST_EMPTY) || Ack) begin
        Z_parallel <= word_next;
        state      <= ST_FULL;
        Ovf        <= 1'b0;
      end else begin
        Ovf <= 1'b1;
      end
    end else if (Ack && (state == ST_FULL)) begin
      state <= ST_EMPTY;
      Ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shiftin.sv
// tb/tb_shiftin.sv - scoreboard bench for the shiftin deserializer
module tb_shiftin;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        Sx = 1'b0;
  logic        Z_in = 1'b0;
  logic        Ack = 1'b0;
  logic [15:0] Z_parallel;
  logic        Fx;
  logic        Ovf;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  // Expected snapshot {Z_parallel, Fx, Ovf, Busy} for each visible change of the output word/flags.
  logic [18:0] exp_q[$];

  shiftin dut (
    .Clk        (Clk),
    .reset      (reset),
    .Sx         (Sx),
    .Z_in       (Z_in),
    .Ack        (Ack),
    .Z_parallel (Z_parallel),
    .Fx         (Fx),
    .Ovf        (Ovf),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_event(input logic [15:0] z, input logic fx, input logic ovf, input logic busy);
    exp_q.push_back({z, fx, ovf, busy});
  endtask

  task automatic send_bit(input logic b, input logic ack_now);
    Sx   = 1'b1;
    Z_in = b;
    Ack  = ack_now;
    @(posedge Clk);
    #1;
    Sx   = 1'b0;
    Z_in = 1'b0;
    Ack  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic ack_last);
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i], ack_last && (i == 15));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    @(posedge Clk);
    #1;
    Ack = 1'b0;
  endtask

  // Monitor: any change of word/flags must match the next queued expectation.
  logic [17:0] prev_out = '0;
  always @(negedge Clk) begin
    logic [17:0] cur;
    logic [18:0] exp_v;
    cur = {Z_parallel, Fx, Ovf};
    if (cur !== prev_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: got %h expected no change from %h", cur, prev_out);
      end else begin
        exp_v = exp_q.pop_front();
        check("output_event", {13'd0, cur, Busy}, {13'd0, exp_v});
      end
      prev_out = cur;
    end
  end

  initial begin
    logic [15:0] w;

    #1;
    check("reset_outputs", {13'd0, Z_parallel, Fx, Ovf, Busy}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Plain word, then ack.
    expect_event(16'hA5C3, 1'b1, 1'b0, 1'b0);
    send_word(16'hA5C3, 1'b0);
    check("a5c3_fx", {31'd0, Fx}, 32'd1);
    check("a5c3_busy", {31'd0, Busy}, 32'd0);
    expect_event(16'hA5C3, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    check("a5c3_held", {16'd0, Z_parallel}, 32'h0000A5C3);
    idle(2);

    // Pauses mid-word keep the bit index.
    expect_event(16'h1234, 1'b1, 1'b0, 1'b0);
    w = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i], 1'b0);
      if (i == 4 || i == 11) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          check("gap_busy", {31'd0, Busy}, 32'd1);
          check("gap_fx", {31'd0, Fx}, 32'd0);
        end
      end
    end
    check("1234_fx", {31'd0, Fx}, 32'd1);
    expect_event(16'h1234, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    idle(2);

    // Back-to-back, ack coinciding with second completion: no overrun.
    expect_event(16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0);
    expect_event(16'h0001, 1'b1, 1'b0, 1'b0);
    send_word(16'h0001, 1'b1);
    check("b2b_fx", {31'd0, Fx}, 32'd1);
    check("b2b_ovf", {31'd0, Ovf}, 32'd0);
    expect_event(16'h0001, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    idle(2);

    // Overrun: second word dropped, Ovf sticky until ack.
    expect_event(16'hBEEF, 1'b1, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b0);
    expect_event(16'hBEEF, 1'b1, 1'b1, 1'b0);
    send_word(16'hDEAD, 1'b0);
    idle(2);
    check("ovf_sticky", {31'd0, Ovf}, 32'd1);
    expect_event(16'hBEEF, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    idle(2);

    // Async reset mid-word.
    w = 16'hCAFE;
    for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
    check("partial_busy", {31'd0, Busy}, 32'd1);
    expect_event(16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {13'd0, Z_parallel, Fx, Ovf, Busy}, 32'd0);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    idle(1);
    expect_event(16'h00FF, 1'b1, 1'b0, 1'b0);
    w = 16'h00FF;
    for (int i = 0; i < 15; i++) send_bit(w[i], 1'b0);
    check("post_reset_15_fx", {31'd0, Fx}, 32'd0);
    check("post_reset_15_busy", {31'd0, Busy}, 32'd1);
    send_bit(w[15], 1'b0);
    check("post_reset_16_fx", {31'd0, Fx}, 32'd1);
    expect_event(16'h00FF, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    idle(1);

    // Ack while empty is ignored.
    pulse_ack();
    idle(1);
    check("empty_ack", {13'd0, Z_parallel, Fx, Ovf, Busy}, {13'd0, 16'h00FF, 3'b000});
    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
